ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver, byte FIFO and scan-code set 2 decoder.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       is_extended,
    output logic       is_shift,
    output logic       is_capital,
    output logic       overflow,
    output logic       parity_err
);

    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] B_EXT   = 8'hE0;
    localparam logic [7:0] B_BRK   = 8'hF0;
    localparam logic [7:0] B_LSH   = 8'h12;
    localparam logic [7:0] B_RSH   = 8'h59;
    localparam logic [7:0] B_CAPS  = 8'h58;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } state_t;

    // ---------------- synchronizers ----------------
    logic [2:0] kclk_sync_q, kclk_sync_d;
    logic [2:0] kdat_sync_q, kdat_sync_d;
    logic       kclk_fall;
    logic       bit_in;

    always_comb begin
        kclk_sync_d = {kclk_sync_q[1:0], ps2_clk};
        kdat_sync_d = {kdat_sync_q[1:0], ps2_data};
    end

    assign kclk_fall = (kclk_sync_q[2:1] == 2'b10);
    assign bit_in    = kdat_sync_q[1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            kclk_sync_q <= 3'b111;
            kdat_sync_q <= 3'b111;
        end else begin
            kclk_sync_q <= kclk_sync_d;
            kdat_sync_q <= kdat_sync_d;
        end
    end

    // ---------------- frame receiver ----------------
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            wr_pend_q, wr_pend_d;
    logic [7:0]      wr_byte_q, wr_byte_d;
    logic [10:0]     frame;
    logic            framing_ok;
    logic            frame_ok;

    assign frame      = {bit_in, shift_q};
    assign framing_ok = !frame[0] && frame[10];

`ifdef PS2_PARITY_CHECK_EN
    logic perr_q, perr_d;

    assign frame_ok   = framing_ok && (^frame[9:1]);
    assign parity_err = perr_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) perr_q <= 1'b0;
        else       perr_q <= perr_d;
    end

    always_comb begin
        perr_d = 1'b0;
        if (kclk_fall && bit_cnt_q == 4'd10 && !frame_ok)
            perr_d = 1'b1;
    end
`else
    logic unused_parity_bit;

    assign unused_parity_bit = frame[9];
    assign frame_ok          = framing_ok;
    assign parity_err        = 1'b0;
`endif

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        wr_pend_d = 1'b0;
        wr_byte_d = wr_byte_q;
        if (kclk_fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (frame_ok) begin
                    wr_pend_d = 1'b1;
                    wr_byte_d = frame[8:1];
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {bit_in, shift_q[9:1]};
            end
        end else if (bit_cnt_q != 4'd0) begin
            // Stalled partial frame: drop it silently
            if (to_cnt_q == TO_LAST) begin
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
            to_cnt_q  <= '0;
            wr_pend_q <= 1'b0;
            wr_byte_q <= 8'h00;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            to_cnt_q  <= to_cnt_d;
            wr_pend_q <= wr_pend_d;
            wr_byte_q <= wr_byte_d;
        end
    end

    // ---------------- byte FIFO ----------------
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           overflow_q, overflow_d;
    logic           fifo_empty;
    logic           fifo_full;
    logic           do_wr;
    logic           pop;
    logic           pop_hold;
    logic [7:0]     rd_byte;

    // Held low in silicon; a bench may force it to stall the decoder
    assign pop_hold = 1'b0;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_wr      = wr_pend_q && !fifo_full;
    assign pop        = !fifo_empty && !pop_hold;
    assign rd_byte    = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (do_wr)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_pend_q && fifo_full)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_byte_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------- scan-code decoder ----------------
    state_t     state_q, state_d;
    logic [7:0] key_code_q, key_code_d;
    logic       is_ext_q, is_ext_d;
    logic       key_valid_q, key_valid_d;
    logic       lsh_q, lsh_d;
    logic       rsh_q, rsh_d;
    logic       caps_q, caps_d;
    logic       caps_held_q, caps_held_d;
    logic       code_ev;
    logic       ev_brk;
    logic       ev_ext;

    always_comb begin
        state_d = state_q;
        code_ev = 1'b0;
        ev_brk  = 1'b0;
        ev_ext  = 1'b0;
        if (pop) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rd_byte == B_EXT)      state_d = S_EXT;
                    else if (rd_byte == B_BRK) state_d = S_BRK;
                    else                       code_ev = 1'b1;
                end
                S_EXT: begin
                    if (rd_byte == B_BRK) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        code_ev = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    code_ev = 1'b1;
                    ev_brk  = 1'b1;
                    state_d = S_IDLE;
                end
                S_EXT_BRK: begin
                    code_ev = 1'b1;
                    ev_brk  = 1'b1;
                    ev_ext  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        key_code_d  = key_code_q;
        is_ext_d    = is_ext_q;
        key_valid_d = 1'b0;
        lsh_d       = lsh_q;
        rsh_d       = rsh_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        if (code_ev) begin
            unique case (1'b1)
                (!ev_ext && rd_byte == B_LSH): lsh_d = !ev_brk;
                (!ev_ext && rd_byte == B_RSH): rsh_d = !ev_brk;
                (ev_ext && rd_byte == B_LSH): begin
                    // Fake shift emitted around extended keys
                end
                (!ev_ext && rd_byte == B_CAPS): begin
                    if (ev_brk) begin
                        caps_held_d = 1'b0;
                    end else begin
                        if (!caps_held_q)
                            caps_d = !caps_q;
                        caps_held_d = 1'b1;
                    end
                end
                default: begin
                    if (!ev_brk) begin
                        key_code_d  = rd_byte;
                        is_ext_d    = ev_ext;
                        key_valid_d = 1'b1;
                    end else if (rd_byte == key_code_q &&
                                 ev_ext == is_ext_q) begin
                        key_code_d = 8'h00;
                        is_ext_d   = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            key_code_q  <= 8'h00;
            is_ext_q    <= 1'b0;
            key_valid_q <= 1'b0;
            lsh_q       <= 1'b0;
            rsh_q       <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            is_ext_q    <= is_ext_d;
            key_valid_q <= key_valid_d;
            lsh_q       <= lsh_d;
            rsh_q       <= rsh_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
        end
    end

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign is_extended = is_ext_q;
    assign is_shift    = lsh_q | rsh_q;
    assign is_capital  = caps_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a scan-code reference model.
// Covers both builds of PS2_PARITY_CHECK_EN.
module tb_ps2_key_decoder;

    localparam int TO    = 100;
    localparam int DEPTH = 8;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_valid;
    logic       is_extended;
    logic       is_shift;
    logic       is_capital;
    logic       overflow;
    logic       parity_err;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .is_extended(is_extended),
        .is_shift   (is_shift),
        .is_capital (is_capital),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       shift;
        logic       caps;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_code;
    logic       m_ext, m_lsh, m_rsh, m_caps, m_caps_held, m_ovf;
    logic       m_e0, m_f0;
    int         m_perr;
    bit         settled = 0;
    bit         lat_chk = 1;
    int         last_fall = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_code = 8'h00; m_ext = 0; m_lsh = 0; m_rsh = 0;
        m_caps = 0; m_caps_held = 0; m_ovf = 0;
        m_e0 = 0; m_f0 = 0; m_perr = 0;
        exp_q.delete();
    endtask

    // Scan-code set 2 rules applied to one accepted byte
    task automatic model_byte(input logic [7:0] b);
        logic ext, brk;
        exp_t e;
        if (!m_f0 && b == 8'hF0) begin
            m_f0 = 1;
        end else if (!m_e0 && !m_f0 && b == 8'hE0) begin
            m_e0 = 1;
        end else begin
            ext = m_e0; brk = m_f0;
            m_e0 = 0; m_f0 = 0;
            if (!ext && b == 8'h12) m_lsh = !brk;
            else if (!ext && b == 8'h59) m_rsh = !brk;
            else if (ext && b == 8'h12) begin
            end else if (!ext && b == 8'h58) begin
                if (brk) m_caps_held = 0;
                else begin
                    if (!m_caps_held) m_caps = !m_caps;
                    m_caps_held = 1;
                end
            end else if (!brk) begin
                m_code = b; m_ext = ext;
                e.code = b; e.ext = ext;
                e.shift = m_lsh | m_rsh; e.caps = m_caps;
                exp_q.push_back(e);
            end else if (b == m_code && ext == m_ext) begin
                m_code = 8'h00; m_ext = 0;
            end
        end
    endtask

    task automatic frame_model(input logic [7:0] b, input bit bad);
`ifdef PS2_PARITY_CHECK_EN
        if (bad) m_perr++;
        else     model_byte(b);
`else
        model_byte(b);
`endif
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad,
                             input int nbits);
        logic [10:0] f;
        settled = 0;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) last_fall = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad = 0);
        frame_model(b, bad);
        send_bits(b, bad, 11);
        repeat (12) @(negedge clk);
        settled = 1;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (clrn) begin
            if (key_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected key_valid: code %0h, none expected",
                             key_code);
                end else begin
                    e = exp_q.pop_front();
                    chk("kv key_code", key_code, e.code);
                    chk("kv is_extended", is_extended, e.ext);
                    chk("kv is_shift", is_shift, e.shift);
                    chk("kv is_capital", is_capital, e.caps);
                    if (lat_chk)
                        chk("kv latency", cyc - last_fall, 5);
                end
            end
            if (parity_err) begin
                tests++;
                if (m_perr == 0) begin
                    fails++;
                    $display("FAIL unexpected parity_err: got 1, expected 0");
                end else begin
                    m_perr--;
                end
            end
            if (settled) begin
                chk("key_code", key_code, m_code);
                chk("is_extended", is_extended, m_ext);
                chk("is_shift", is_shift, m_lsh | m_rsh);
                chk("is_capital", is_capital, m_caps);
                chk("overflow", overflow, m_ovf);
                chk("pending key_valid", exp_q.size(), 0);
                chk("pending parity_err", m_perr, 0);
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst key_code", key_code, 8'h00);
        chk("rst key_valid", key_valid, 0);
        chk("rst is_extended", is_extended, 0);
        chk("rst is_shift", is_shift, 0);
        chk("rst is_capital", is_capital, 0);
        chk("rst overflow", overflow, 0);
        chk("rst parity_err", parity_err, 0);
    endtask

    logic [7:0] ob [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                           8'h35, 8'h3C, 8'h43, 8'h44};

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1 chk_reset_vals();
        @(negedge clk);
        clrn = 1'b1;
        repeat (4) @(negedge clk);

        // press and release
        frame(8'h1C);
        chk("lit make 1C", key_code, 8'h1C);
        chk("lit make 1C ext", is_extended, 0);
        frame(8'hF0); frame(8'h1C);
        chk("lit break 1C", key_code, 8'h00);

        // shift around a key
        frame(8'h12); frame(8'h1C);
        chk("lit shift held", is_shift, 1);
        frame(8'hF0); frame(8'h12);
        chk("lit shift released", is_shift, 0);
        chk("lit key after shift", key_code, 8'h1C);
        frame(8'hF0); frame(8'h1C);

        // caps lock toggle
        frame(8'h58);
        chk("lit caps first", is_capital, 1);
        frame(8'h58);
        chk("lit caps repeat", is_capital, 1);
        frame(8'hF0); frame(8'h58);
        chk("lit caps break", is_capital, 1);
        frame(8'h58);
        chk("lit caps second", is_capital, 0);

        // extended key
        frame(8'hE0); frame(8'h75);
        chk("lit ext make", key_code, 8'h75);
        chk("lit ext flag", is_extended, 1);
        frame(8'hE0); frame(8'hF0); frame(8'h75);
        chk("lit ext break", key_code, 8'h00);
        chk("lit ext break flag", is_extended, 0);

        // typematic repeat, foreign break, fake shift, right shift
        frame(8'h1C); frame(8'h1C);
        frame(8'hF0); frame(8'h23);
        chk("lit foreign break", key_code, 8'h1C);
        frame(8'hE0); frame(8'h12);
        chk("lit fake shift", is_shift, 0);
        frame(8'h59);
        chk("lit rshift", is_shift, 1);
        frame(8'hF0); frame(8'h59);
        frame(8'hF0); frame(8'h1C);

        // bad parity, then clean release
        frame(8'h1C, 1);
        frame(8'hF0); frame(8'h1C);

        // stalled partial frame then a full one
        send_bits(8'h1C, 0, 9);
        repeat (TO + 50) @(negedge clk);
        frame(8'h1C);
        chk("lit after timeout", key_code, 8'h1C);
        frame(8'hF0); frame(8'h1C);

        // reset mid-frame with shift held
        frame(8'h12);
        send_bits(8'h1C, 0, 5);
        @(negedge clk);
        clrn = 1'b0;
        model_reset();
        #1 chk_reset_vals();
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        frame(8'h1C);
        chk("lit after reset", key_code, 8'h1C);
        frame(8'hF0); frame(8'h1C);

        // FIFO overflow with the decoder stalled
        lat_chk = 0;
        settled = 0;
        force dut.pop_hold = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) frame_model(ob[i], 0);
            send_bits(ob[i], 0, 11);
            repeat (4) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("lit overflow", overflow, 1);
        m_ovf = 1;
        release dut.pop_hold;
        repeat (20) @(negedge clk);
        settled = 1;
        chk("lit last in order", key_code, 8'h43);
        repeat (5) @(negedge clk);

        chk("all key_valid seen", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
